fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage for the LEGv8 core. It sits directly upstream of decode, which holds the register file, control and the sign extender. It supplies each 32-bit instruction word and its PC.
- Holds the PC, issues word requests to instruction memory, and buffers the returned word behind a valid/ready handshake.
- Takes branch redirects as branch PC plus the sign-extended word offset, and computes the target internally.

Parameters:
N, 64, PC and address width in bits
RESET_PC, 64'h0, PC loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
imem_req  out  1  one-cycle request pulse to instruction memory
imem_addr  out  N  byte address of request; valid only while imem_req=1
imem_rvalid  in  1  response strobe, at least 1 cycle after the request
imem_rdata  in  32  instruction word, valid while imem_rvalid=1
instr_o  out  32  fetched instruction to decode
instr_pc_o  out  N  PC of instr_o
instr_valid_o  out  1  instr_o/instr_pc_o valid
instr_ready_i  in  1  decode accepts the instruction this cycle
redirect_i  in  1  taken branch/jump this cycle
redirect_pc_i  in  N  PC of the redirecting instruction
redirect_imm_i  in  N  sign-extended word offset, as produced by the sign extender

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, state=S_FETCH, imem_req=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- At most one outstanding memory request at any time.
- Target arithmetic: target = redirect_pc_i + (redirect_imm_i << 2), modulo 2^N. Sequential next PC = pc + 4, modulo 2^N, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- State S_FETCH:
  - imem_req=1, imem_addr=pc.
  - Next state S_WAIT.
- State S_WAIT:
  - On imem_rvalid: instr_o<=imem_rdata, instr_pc_o<=pc, instr_valid_o<=1, pc<=pc+4.
  - Next state S_HOLD.
- State S_HOLD:
  - Outputs held stable while instr_ready_i=0.
  - Handshake = instr_valid_o & instr_ready_i. On handshake: instr_valid_o<=0, next state S_FETCH.
  - Throughput with 1-cycle memory and ready held high: one instruction per 3 cycles.
- State S_DROP:
  - Waits for the squashed response; on imem_rvalid the data is discarded and the next state is S_FETCH.
- imem_rvalid is ignored in S_FETCH and S_HOLD.
- Redirect rules (redirect_i has priority over all other events):
  - Any state: pc<=target, instr_valid_o<=0 next cycle.
  - From S_WAIT without rvalid: next state S_DROP.
  - From S_WAIT with rvalid in the same cycle: response discarded, next state S_FETCH.
  - From S_DROP: pc updated, stay in S_DROP.
  - From S_HOLD: next state S_FETCH. If instr_ready_i is also high, the handshake counts as completed.
  - From S_FETCH: the request this cycle still issues at the old pc, then next state S_DROP.
- Reset mid-operation: instruction memory shares the same reset and abandons outstanding requests, so no stale response can arrive after reset.
- The block performs no alignment check; the target alignment is inherited from redirect_pc_i.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two ports, both cleared on reset and wrapping at 2^32:
  - fetch_count_o  out  32: increments on each decode handshake.
  - squash_count_o  out  32: increments on each discarded response.
- When undefined, both ports and both counters are absent. Core behaviour is identical either way.

Decomposition:
- Package fetch_pkg holds:
  - the state enum fetch_state_t {S_FETCH, S_WAIT, S_HOLD, S_DROP};
  - constants INSTR_W=32 and INSTR_BYTES=4.
- One sub-module, pc_target: combinational target = pc + (imm << 2), parameterised by N. Execute reuses it for branch address computation.

Test Plan:
- Reset, 1-cycle memory, ready=1 → imem_addr sequence 0x0, 0x4, 0x8. First instr_o=F84003E0 with instr_pc_o=0x0; requests spaced 3 cycles apart.
- Backpressure: instr_ready_i=0 for 5 cycles with instr_o=B80043E0 at pc 0x4 → outputs stable for all 5 cycles, no imem_req. Ready raised → next request at 0x8.
- Redirect in S_HOLD with redirect_pc_i=0x10, redirect_imm_i=0xFFFF_FFFF_FFFF_FFFE → next imem_addr=0x08, held instruction withdrawn.
- Redirect in S_WAIT with redirect_pc_i=0x20, imm=0x2, response arriving 3 cycles later → response dropped, instr_valid_o stays 0, next imem_addr=0x28.
- Wrap: RESET_PC=0xFFFF_FFFF_FFFF_FFFC → second request address 0x0. Reset asserted mid-S_WAIT → next request at RESET_PC and instr_valid_o=0.
- FETCH_PERF_EN defined, 4 accepted instructions and 1 squash → fetch_count_o=4, squash_count_o=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 instruction fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   INSTR_W       : instruction word width in bits
//   INSTR_BYTES   : bytes per instruction (sequential PC step)
package fetch_pkg;

   localparam int unsigned INSTR_W     = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_HOLD,
      S_DROP
   } fetch_state_t;

endpackage

// File: rtl/pc_target.sv
// Word-offset branch target adder, shared with execute for branch address computation.
//   pc_i     : base PC (byte address)
//   imm_i    : sign-extended word offset
//   target_o : pc_i + imm_i * INSTR_BYTES, modulo 2^N
module pc_target
   import fetch_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic [N-1:0] pc_i,
   input  logic [N-1:0] imm_i,
   output logic [N-1:0] target_o
);

   assign target_o = pc_i + (imm_i << $clog2(INSTR_BYTES));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-outstanding word requests to
// instruction memory and presents the returned word to decode behind valid/ready.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   imem_req/imem_addr           : one-cycle request pulse and byte address
//   imem_rvalid/imem_rdata       : memory response strobe and instruction word
//   instr_o/instr_pc_o           : instruction and its PC to decode
//   instr_valid_o/instr_ready_i  : decode handshake
//   redirect_i/redirect_pc_i/
//   redirect_imm_i               : taken branch, its PC and sign-extended word offset
//   fetch_count_o/squash_count_o : accepted / discarded counters (FETCH_PERF_EN only)
// Optional feature macro: FETCH_PERF_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned  N        = 64,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [N-1:0]       imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_o,
   output logic [N-1:0]       instr_pc_o,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   input  logic               redirect_i,
   input  logic [N-1:0]       redirect_pc_i,
   input  logic [N-1:0]       redirect_imm_i
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_count_o,
   output logic [31:0]        squash_count_o
`endif
);

   fetch_state_t       state_q, state_d;
   logic [N-1:0]       pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [N-1:0]       ipc_q, ipc_d;
   logic               valid_q, valid_d;
   logic               handshake;
   logic               discard;
   logic [N-1:0]       tgt_base, tgt_imm, tgt;

   // One adder serves both redirects and the sequential step: pc + (1 << 2) = pc + 4.
   assign tgt_base = redirect_i ? redirect_pc_i : pc_q;
   assign tgt_imm  = redirect_i ? redirect_imm_i : N'(1);

   pc_target #(
      .N (N)
   ) u_pc_target (
      .pc_i     (tgt_base),
      .imm_i    (tgt_imm),
      .target_o (tgt)
   );

   assign handshake = (state_q == S_HOLD) & valid_q & instr_ready_i;
   // A response is thrown away when it belongs to a squashed request.
   assign discard   = imem_rvalid &
                      (((state_q == S_WAIT) & redirect_i) | (state_q == S_DROP));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      unique case (state_q)
         S_FETCH: begin
            state_d = redirect_i ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (redirect_i) begin
               state_d = discard ? S_FETCH : S_DROP;
            end else if (imem_rvalid) begin
               instr_d = imem_rdata;
               ipc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = tgt;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_i || handshake) begin
               valid_d = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_DROP: begin
            // The squashed response has landed even if a new redirect arrives with it,
            // so nothing further is outstanding and waiting here again would deadlock.
            if (discard) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
      if (redirect_i) begin
         pc_d    = tgt;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
      end
   end

   assign imem_req      = (state_q == S_FETCH) & ~reset;
   assign imem_addr     = pc_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = ipc_q;
   assign instr_valid_o = valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, squash_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         if (handshake) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (discard)   squash_cnt_q <= squash_cnt_q + 32'd1;
      end
   end

   assign fetch_count_o  = fetch_cnt_q;
   assign squash_count_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model checked every cycle plus
// directed scenarios with literal expectations. A second instance with a wrapping
// RESET_PC shares the stimulus.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_ready_i = 1'b1;
   logic        redirect_i = 1'b0;
   logic [63:0] redirect_pc_i = '0;
   logic [63:0] redirect_imm_i = '0;

   logic        imem_req, w_imem_req;
   logic [63:0] imem_addr, w_imem_addr;
   logic [31:0] instr_o, w_instr_o;
   logic [63:0] instr_pc_o, w_instr_pc_o;
   logic        instr_valid_o, w_instr_valid_o;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_o, squash_count_o, w_fetch_count_o, w_squash_count_o;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.N(64), .RESET_PC(64'h0)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_o        (instr_o),
      .instr_pc_o     (instr_pc_o),
      .instr_valid_o  (instr_valid_o),
      .instr_ready_i  (instr_ready_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .redirect_imm_i (redirect_imm_i)
`ifdef FETCH_PERF_EN
      ,
      .fetch_count_o  (fetch_count_o),
      .squash_count_o (squash_count_o)
`endif
   );

   fetch_unit #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (w_imem_req),
      .imem_addr      (w_imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_o        (w_instr_o),
      .instr_pc_o     (w_instr_pc_o),
      .instr_valid_o  (w_instr_valid_o),
      .instr_ready_i  (instr_ready_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .redirect_imm_i (redirect_imm_i)
`ifdef FETCH_PERF_EN
      ,
      .fetch_count_o  (w_fetch_count_o),
      .squash_count_o (w_squash_count_o)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == 64'h0) return 32'hF840_03E0;
      if (a == 64'h4) return 32'hB800_43E0;
      return {8'hD1, a[23:0]};
   endfunction

   // Instruction memory: answers the main instance's request mem_lat cycles later.
   int mem_lat = 1;
   initial begin
      bit          pend;
      int          cnt;
      logic [63:0] paddr;
      pend = 1'b0;
      cnt = 0;
      paddr = '0;
      forever begin
         @(negedge clk);
         if (reset) pend = 1'b0;
         else if (imem_req) begin
            pend = 1'b1;
            cnt = mem_lat;
            paddr = imem_addr;
         end
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         imem_rdata = '0;
         if (pend && !reset) begin
            cnt--;
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata = mem_word(paddr);
               pend = 1'b0;
            end
         end
      end
   end

   // Logs for the directed checks.
   logic [63:0] req_addr_q[$];
   int          req_cyc_q[$];
   logic [63:0] w_addr_q[$];
   logic [31:0] hs_word_q[$];
   logic [63:0] hs_pc_q[$];
   int          cyc = 0;

   // Model: PC, an in-flight request (possibly doomed), a held instruction, and whether
   // a request goes out this cycle.
   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_word;
   bit          m_valid, m_issue, m_out, m_disc, m_init;
   int unsigned m_fetched, m_squashed;

   initial begin
      bit resp, hs;
      m_init = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (m_init) begin
            chk("req", imem_req, m_issue && !reset);
            if (m_issue && !reset) chk("addr", imem_addr, m_pc);
            chk("valid", instr_valid_o, m_valid);
            if (m_valid) begin
               chk("instr", instr_o, m_word);
               chk("instr_pc", instr_pc_o, m_ipc);
            end
`ifdef FETCH_PERF_EN
            chk("fetch_count", fetch_count_o, 64'(m_fetched));
            chk("squash_count", squash_count_o, 64'(m_squashed));
`endif
         end
         if (imem_req) begin
            req_addr_q.push_back(imem_addr);
            req_cyc_q.push_back(cyc);
         end
         if (w_imem_req) w_addr_q.push_back(w_imem_addr);
         if (!reset && instr_valid_o && instr_ready_i) begin
            hs_word_q.push_back(instr_o);
            hs_pc_q.push_back(instr_pc_o);
         end
         if (reset) begin
            m_pc = 64'h0; m_ipc = '0; m_word = '0;
            m_valid = 0; m_issue = 1; m_out = 0; m_disc = 0;
            m_fetched = 0; m_squashed = 0; m_init = 1;
         end else begin
            resp = m_out && imem_rvalid;
            hs   = m_valid && instr_ready_i;
            if (redirect_i) begin
               m_pc = redirect_pc_i + redirect_imm_i * 64'd4;
               m_valid = 0;
               if (m_issue) begin
                  m_issue = 0; m_out = 1; m_disc = 1;
               end else if (m_out && !resp) begin
                  m_disc = 1;
               end else if (m_out) begin
                  m_out = 0; m_issue = 1; m_squashed++;
               end else begin
                  m_issue = 1;
                  if (hs) m_fetched++;
               end
            end else if (m_issue) begin
               m_issue = 0; m_out = 1; m_disc = 0;
            end else if (resp) begin
               m_out = 0;
               if (m_disc) begin
                  m_issue = 1; m_squashed++;
               end else begin
                  m_valid = 1; m_word = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 64'd4;
               end
            end else if (hs) begin
               m_valid = 0; m_issue = 1; m_fetched++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      req_addr_q.delete(); req_cyc_q.delete(); w_addr_q.delete();
      hs_word_q.delete(); hs_pc_q.delete();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic wait_reqs(input int n);
      for (int i = 0; i < 80 && req_addr_q.size() < n; i++) tick();
      chk("wait_req", 64'(req_addr_q.size() >= n), 64'd1);
   endtask

   task automatic wait_hs(input int n);
      for (int i = 0; i < 80 && hs_word_q.size() < n; i++) tick();
      chk("wait_hs", 64'(hs_word_q.size() >= n), 64'd1);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && !instr_valid_o; i++) begin
         @(negedge clk);
         #1;
      end
      chk("wait_valid", instr_valid_o, 1'b1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", instr_valid_o, 1'b0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_instr_pc", instr_pc_o, 64'h0);

      // Sequential fetch, 1-cycle memory, ready high
      mem_lat = 1;
      instr_ready_i = 1'b1;
      tick();
      do_reset(1);
      wait_reqs(3);
      if (req_addr_q.size() >= 3) begin
         chk("seq_addr0", req_addr_q[0], 64'h0);
         chk("seq_addr1", req_addr_q[1], 64'h4);
         chk("seq_addr2", req_addr_q[2], 64'h8);
         chk("seq_gap1", 64'(req_cyc_q[1] - req_cyc_q[0]), 64'd3);
         chk("seq_gap2", 64'(req_cyc_q[2] - req_cyc_q[1]), 64'd3);
      end
      if (w_addr_q.size() >= 3) begin
         chk("wrap_addr0", w_addr_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
         chk("wrap_addr1", w_addr_q[1], 64'h0);
         chk("wrap_addr2", w_addr_q[2], 64'h4);
      end else chk("wrap_reqs", 64'(w_addr_q.size()), 64'd3);
      wait_hs(1);
      if (hs_word_q.size() >= 1) begin
         chk("first_instr", hs_word_q[0], 32'hF840_03E0);
         chk("first_pc", hs_pc_q[0], 64'h0);
      end

      // Backpressure on the instruction at pc 0x4
      do_reset(2);
      wait_hs(1);
      instr_ready_i = 1'b0;
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("bp_valid", instr_valid_o, 1'b1);
         chk("bp_instr", instr_o, 32'hB800_43E0);
         chk("bp_pc", instr_pc_o, 64'h4);
         chk("bp_noreq", imem_req, 1'b0);
      end
      tick();
      req_addr_q.delete();
      instr_ready_i = 1'b1;
      wait_reqs(1);
      if (req_addr_q.size() >= 1) chk("bp_next_addr", req_addr_q[0], 64'h8);

      // Redirect while holding
      instr_ready_i = 1'b0;
      do_reset(2);
      wait_valid();
      tick();
      redirect_i = 1'b1;
      redirect_pc_i = 64'h10;
      redirect_imm_i = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      redirect_i = 1'b0;
      @(negedge clk);
      #1;
      chk("hold_rd_valid", instr_valid_o, 1'b0);
      chk("hold_rd_req", imem_req, 1'b1);
      chk("hold_rd_addr", imem_addr, 64'h8);
      instr_ready_i = 1'b1;
      repeat (6) tick();

      // Redirect while waiting on a 3-cycle memory
      mem_lat = 3;
      do_reset(2);
      wait_reqs(1);
      redirect_i = 1'b1;
      redirect_pc_i = 64'h20;
      redirect_imm_i = 64'h2;
      tick();
      redirect_i = 1'b0;
      wait_reqs(2);
      if (req_addr_q.size() >= 2) begin
         chk("wait_rd_addr", req_addr_q[1], 64'h28);
         chk("wait_rd_gap", 64'(req_cyc_q[1] - req_cyc_q[0]), 64'd4);
      end
      chk("wait_rd_valid", instr_valid_o, 1'b0);
      wait_hs(4);
      if (hs_pc_q.size() >= 4) begin
         chk("wait_rd_pc0", hs_pc_q[0], 64'h28);
         chk("wait_rd_pc3", hs_pc_q[3], 64'h34);
      end
`ifdef FETCH_PERF_EN
      @(negedge clk);
      #1;
      chk("perf_fetch", fetch_count_o, 32'd4);
      chk("perf_squash", squash_count_o, 32'd1);
`endif

      // Reset in the middle of a wait
      clear_logs();
      wait_reqs(1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_logs();
      @(negedge clk);
      #1;
      chk("mid_rst_req", imem_req, 1'b1);
      chk("mid_rst_addr", imem_addr, 64'h0);
      chk("mid_rst_valid", instr_valid_o, 1'b0);
      chk("mid_rst_waddr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      wait_hs(1);
      if (hs_word_q.size() >= 1) begin
         chk("mid_rst_instr", hs_word_q[0], 32'hF840_03E0);
         chk("mid_rst_pc", hs_pc_q[0], 64'h0);
      end
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
